// File: rtl/demux_4_stream.sv
// demux_4_stream
//   Four-way stream demultiplexer. One WIDTH-bit word per cycle enters on a
//   single valid/ready channel and is steered by IN_SEL into one of four
//   2-entry FIFOs. Each FIFO drives its own valid/ready output channel, so a
//   stalled consumer only blocks words addressed to it.
//
// Ports
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset
//   IN_VALID   in   input word present
//   IN_READY   out  FIFO[IN_SEL] has room (depends only on IN_SEL + occupancy)
//   IN_SEL     in   destination channel 0..3
//   IN_DATA    in   input word
//   OUT_VALID  out  bit k: channel k holds a word
//   OUT_READY  in   bit k: channel k consumer accepts
//   OUT_DATA   out  channel k head word on [k*WIDTH +: WIDTH]
//   OUT_CNT    out  channel k delivery count on [k*CNT_WIDTH +: CNT_WIDTH]
//                   (only when DEMUX4_CNT_EN is defined)
//
// Build option
//   DEMUX4_CNT_EN : adds OUT_CNT and the per-channel wrapping delivery counters.

module demux_4_stream #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [1:0]             IN_SEL,
    input  logic [WIDTH-1:0]       IN_DATA,
    output logic [3:0]             OUT_VALID,
    input  logic [3:0]             OUT_READY,
    output logic [4*WIDTH-1:0]     OUT_DATA
`ifdef DEMUX4_CNT_EN
    ,
    output logic [4*CNT_WIDTH-1:0] OUT_CNT
`endif
);

    // Elaboration-time sanity check on the configuration.
    if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("demux_4_stream: WIDTH and CNT_WIDTH must be at least 1");
    end

    logic [1:0]       occ_q    [4];
    logic [1:0]       occ_d    [4];
    logic [3:0]       wr_ptr_q, wr_ptr_d;
    logic [3:0]       rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q    [4][2];
    logic [WIDTH-1:0] mem_d    [4][2];
    // Registered copy of the FIFO head so OUT_DATA comes straight from a flop
    // rather than through the read-pointer mux.
    logic [WIDTH-1:0] head_q   [4];
    logic [WIDTH-1:0] head_d   [4];
    logic [3:0]       push;
    logic [3:0]       pop;

    // Handshake decode
    always_comb begin
        IN_READY = (occ_q[IN_SEL] != 2'd2);
        OUT_VALID = '0;
        push      = '0;
        pop       = '0;
        OUT_DATA  = '0;
        for (int k = 0; k < 4; k++) begin
            OUT_VALID[k]               = (occ_q[k] != 2'd0);
            push[k]                    = IN_VALID && IN_READY && (IN_SEL == 2'(k));
            pop[k]                     = OUT_VALID[k] && OUT_READY[k];
            OUT_DATA[k*WIDTH +: WIDTH] = head_q[k];
        end
    end

    // FIFO next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int k = 0; k < 4; k++) begin
            occ_d[k]    = occ_q[k];
            mem_d[k][0] = mem_q[k][0];
            mem_d[k][1] = mem_q[k][1];
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = IN_DATA;
                wr_ptr_d[k]           = ~wr_ptr_q[k];
            end
            if (pop[k]) begin
                rd_ptr_d[k] = ~rd_ptr_q[k];
            end
            case ({push[k], pop[k]})
                2'b10:   occ_d[k] = occ_q[k] + 2'd1;
                2'b01:   occ_d[k] = occ_q[k] - 2'd1;
                default: occ_d[k] = occ_q[k];
            endcase
            // Head after this edge: covers push-into-empty and the
            // push+pop-at-occupancy-1 case where the new word becomes head.
            head_d[k] = mem_d[k][rd_ptr_d[k]];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int k = 0; k < 4; k++) begin
                occ_q[k]    <= '0;
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
                head_q[k]   <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int k = 0; k < 4; k++) begin
                occ_q[k]    <= occ_d[k];
                mem_q[k][0] <= mem_d[k][0];
                mem_q[k][1] <= mem_d[k][1];
                head_q[k]   <= head_d[k];
            end
        end
    end

`ifdef DEMUX4_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [4];
    logic [CNT_WIDTH-1:0] cnt_d [4];

    // Delivery counters wrap naturally at 2^CNT_WIDTH.
    always_comb begin
        OUT_CNT = '0;
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k] + {{(CNT_WIDTH-1){1'b0}}, pop[k]};
            OUT_CNT[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
        end
    end
`endif

endmodule

// File: tb/tb_demux_4_stream.sv
// Testbench for demux_4_stream: directed scenarios plus randomized traffic,
// all checked against a queue-per-channel reference model.

module tb_demux_4_stream;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 8;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [1:0]           IN_SEL;
    logic [WIDTH-1:0]     IN_DATA;
    logic [3:0]           OUT_VALID;
    logic [3:0]           OUT_READY;
    logic [4*WIDTH-1:0]   OUT_DATA;
`ifdef DEMUX4_CNT_EN
    logic [4*CNT_WIDTH-1:0] OUT_CNT;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one FIFO queue and one delivery count per channel.
    logic [WIDTH-1:0] mdl [4][$];
    int unsigned      mdl_cnt [4];
    logic [WIDTH-1:0] popped1 [$];

    demux_4_stream #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_SEL    (IN_SEL),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA)
`ifdef DEMUX4_CNT_EN
        ,
        .OUT_CNT   (OUT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            mdl[k].delete();
            mdl_cnt[k] = 0;
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(IN_READY), 64'(mdl[IN_SEL].size() != 2));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid%0d", k), 64'(OUT_VALID[k]), 64'(mdl[k].size() > 0));
            if (mdl[k].size() > 0)
                chk($sformatf("out_data%0d", k), 64'(OUT_DATA[k*WIDTH +: WIDTH]), 64'(mdl[k][0]));
`ifdef DEMUX4_CNT_EN
            chk($sformatf("out_cnt%0d", k), 64'(OUT_CNT[k*CNT_WIDTH +: CNT_WIDTH]),
                64'(CNT_WIDTH'(mdl_cnt[k])));
`endif
        end
    endtask

    // Inputs are driven just after a falling edge; this checks the outputs,
    // advances one rising edge, updates the model and returns after the next
    // falling edge. acc reports whether the model expected the input to be taken.
    task automatic cycle(output bit acc);
        bit             pops [4];
        logic [1:0]     sel;
        logic [WIDTH-1:0] dat;
        #1;
        check_outputs();
        sel = IN_SEL;
        dat = IN_DATA;
        acc = IN_VALID && (mdl[sel].size() != 2);
        for (int k = 0; k < 4; k++) pops[k] = OUT_READY[k] && (mdl[k].size() > 0);
        @(posedge CLK);
        for (int k = 0; k < 4; k++) begin
            if (pops[k]) begin
                if (k == 1) popped1.push_back(mdl[k][0]);
                void'(mdl[k].pop_front());
                mdl_cnt[k]++;
            end
        end
        if (acc) mdl[sel].push_back(dat);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_SEL    = 2'd0;
        IN_DATA   = '0;
        OUT_READY = 4'b0000;
        model_clear();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        bit   acc;
        bit   hold;
        int   guard;
        do_reset();

        // Reset state
        chk("rst_valid", 64'(OUT_VALID), 64'h0);
        chk("rst_data", 64'(OUT_DATA), 64'h0);
        for (int s = 0; s < 4; s++) begin
            IN_SEL = 2'(s);
            #1 chk($sformatf("rst_ready_sel%0d", s), 64'(IN_READY), 64'h1);
        end
        @(negedge CLK);

        // Basic route of A5 to channel 2
        IN_VALID = 1'b1; IN_SEL = 2'd2; IN_DATA = 8'hA5;
        cycle(acc);
        IN_VALID = 1'b0;
        #1;
        chk("a5_valid", 64'(OUT_VALID), 64'h4);
        chk("a5_data", 64'(OUT_DATA[2*WIDTH +: WIDTH]), 64'hA5);
        cycle(acc);

        // Fill channel 1, then backpressure
        IN_VALID = 1'b1; IN_SEL = 2'd1; IN_DATA = 8'h11; cycle(acc);
        IN_DATA = 8'h22; cycle(acc);
        IN_DATA = 8'h33;
        #1 chk("ch1_full_ready", 64'(IN_READY), 64'h0);
        cycle(acc);
        chk("ch1_33_stalled", 64'(acc), 64'h0);
        IN_VALID = 1'b0; IN_SEL = 2'd0;
        #1 chk("ch0_ready_while_ch1_full", 64'(IN_READY), 64'h1);
        IN_VALID = 1'b1; IN_SEL = 2'd1; IN_DATA = 8'h33;
        OUT_READY = 4'b0010;
        popped1.delete();
        guard = 0;
        while (popped1.size() < 3 && guard < 10) begin
            cycle(acc);
            if (acc) IN_VALID = 1'b0;
            guard++;
        end
        IN_VALID = 1'b0;
        chk("ch1_pop_count", 64'(popped1.size()), 64'd3);
        if (popped1.size() == 3) begin
            chk("ch1_order0", 64'(popped1[0]), 64'h11);
            chk("ch1_order1", 64'(popped1[1]), 64'h22);
            chk("ch1_order2", 64'(popped1[2]), 64'h33);
        end

        // Simultaneous push/pop at occupancy 1 on channel 3
        OUT_READY = 4'b0000;
        IN_VALID = 1'b1; IN_SEL = 2'd3; IN_DATA = 8'h44; cycle(acc);
        OUT_READY = 4'b1000; IN_DATA = 8'h55;
        #1 chk("ch3_head44", 64'(OUT_DATA[3*WIDTH +: WIDTH]), 64'h44);
        cycle(acc);
        IN_VALID = 1'b0; OUT_READY = 4'b0000;
        #1;
        chk("ch3_still_valid", 64'(OUT_VALID[3]), 64'h1);
        chk("ch3_head55", 64'(OUT_DATA[3*WIDTH +: WIDTH]), 64'h55);

        // Drain everything
        OUT_READY = 4'b1111;
        repeat (3) cycle(acc);
        chk("drained", 64'(OUT_VALID), 64'h0);

        // Streaming round-robin with all consumers ready
        for (int i = 0; i < 16; i++) begin
            IN_VALID = 1'b1; IN_SEL = 2'(i % 4); IN_DATA = 8'($urandom);
            #1 chk("stream_ready", 64'(IN_READY), 64'h1);
            cycle(acc);
        end
        IN_VALID = 1'b0;
        cycle(acc);

        // Async reset with channels 0 and 1 full
        OUT_READY = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1; IN_SEL = 2'(i / 2); IN_DATA = 8'(8'hC0 + i);
            cycle(acc);
        end
        IN_VALID = 1'b0;
        #1 chk("pre_rst_valid", 64'(OUT_VALID), 64'h3);
        #1 RST_N = 1'b0;
        #1 chk("async_rst_valid", 64'(OUT_VALID), 64'h0);
        model_clear();
        #1 RST_N = 1'b1;
        @(negedge CLK);
        OUT_READY = 4'b1111;
        repeat (3) cycle(acc);

        // Randomized traffic; input is held while stalled
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                IN_VALID = ($urandom_range(0, 3) != 0);
                IN_SEL   = 2'($urandom);
                IN_DATA  = 8'($urandom);
            end
            OUT_READY = 4'($urandom);
            cycle(acc);
            hold = IN_VALID && !acc;
        end
        IN_VALID = 1'b0;
        OUT_READY = 4'b1111;
        repeat (3) cycle(acc);

`ifdef DEMUX4_CNT_EN
        // Counter wrap: 257 deliveries on channel 0
        do_reset();
        OUT_READY = 4'b1111;
        for (int i = 0; i < 257; i++) begin
            IN_VALID = 1'b1; IN_SEL = 2'd0; IN_DATA = 8'(i);
            cycle(acc);
        end
        IN_VALID = 1'b0;
        repeat (2) cycle(acc);
        chk("cnt0_wrap", 64'(OUT_CNT[0 +: CNT_WIDTH]), 64'd1);
        chk("cnt123_zero", 64'(OUT_CNT[4*CNT_WIDTH-1:CNT_WIDTH]), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
